// File: rtl/spi_reg_ctrl_pkg.sv
// rtl/spi_reg_ctrl_pkg.sv - shared types, constants and address helpers for the SPI register sequencer
package spi_reg_ctrl_pkg;

  localparam int         ADDR_W           = 7;
  localparam int         CMD_RW_BIT       = 7;
  localparam logic [7:0] DEFAULT_ERR_BYTE = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RD_REQ,
    ST_RD_LOAD,
    ST_RD_WAIT,
    ST_DROP
  } state_t;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a, input int unsigned num_regs);
    logic [31:0] aw;
    aw = {{(32-ADDR_W){1'b0}}, a};
    return aw < num_regs;
  endfunction

  // Burst addresses wrap back to 0 after the last implemented register.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a, input int unsigned num_regs);
    if (a == ADDR_W'(num_regs - 1)) return '0;
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// rtl/spi_reg_ctrl_if.sv - byte-stream, register-bus and status signals of the SPI register sequencer
interface spi_reg_ctrl_if;
  import spi_reg_ctrl_pkg::*;

  logic              spi_cs;
  logic              rx_dv;
  logic [7:0]        rx_byte;
  logic [7:0]        tx_byte;
  logic              tx_dv;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              busy;
  logic              frame_done;
  logic              err_addr;
  logic              err_ovr;
  logic              err_clr;

  modport master (
    input  spi_cs, rx_dv, rx_byte, reg_rdata, err_clr,
    output tx_byte, tx_dv, reg_addr, reg_wdata, reg_we, reg_re,
           busy, frame_done, err_addr, err_ovr
  );

  modport slave (
    output spi_cs, rx_dv, rx_byte, reg_rdata, err_clr,
    input  tx_byte, tx_dv, reg_addr, reg_wdata, reg_we, reg_re,
           busy, frame_done, err_addr, err_ovr
  );

endinterface

// File: rtl/spi_cs_sync.sv
// rtl/spi_cs_sync.sv - two-flop chip-select synchronizer with frame start/end pulses
module spi_cs_sync (
  input  logic clk,
  input  logic reset,
  input  logic spi_cs,
  output logic cs_start,
  output logic cs_end
);

  logic cs_meta;
  logic cs_sync;
  logic cs_act_d;
  logic cs_act;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_meta  <= 1'b1;
      cs_sync  <= 1'b1;
      cs_act_d <= 1'b0;
    end else begin
      cs_meta  <= spi_cs;
      cs_sync  <= cs_meta;
      cs_act_d <= ~cs_sync;
    end
  end

  assign cs_act   = ~cs_sync;
  assign cs_start = cs_act & ~cs_act_d;
  assign cs_end   = ~cs_act & cs_act_d;

endmodule

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - turns SPI slave bytes into register writes/reads with read data returned one byte behind
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [7:0]  ERR_BYTE = DEFAULT_ERR_BYTE
) (
  input  logic           clk,
  input  logic           reset,
  spi_reg_ctrl_if.master bus
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [ADDR_W-1:0] rx_addr;
  logic [ADDR_W-1:0] reg_addr_nxt;
  logic [7:0]        tx_byte_nxt;
  logic [7:0]        reg_wdata_nxt;
  logic              tx_dv_nxt;
  logic              reg_we_nxt;
  logic              reg_re_nxt;
  logic              set_err_addr;
  logic              set_err_ovr;
  logic              cs_start;
  logic              cs_end;

  spi_cs_sync u_cs_sync (
    .clk      (clk),
    .reset    (reset),
    .spi_cs   (bus.spi_cs),
    .cs_start (cs_start),
    .cs_end   (cs_end)
  );

  assign rx_addr  = bus.rx_byte[ADDR_W-1:0];
  assign bus.busy = (state != ST_IDLE);

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    tx_byte_nxt   = bus.tx_byte;
    tx_dv_nxt     = 1'b0;
    reg_addr_nxt  = bus.reg_addr;
    reg_wdata_nxt = bus.reg_wdata;
    reg_we_nxt    = 1'b0;
    reg_re_nxt    = 1'b0;
    set_err_addr  = 1'b0;
    set_err_ovr   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cs_start) state_nxt = ST_CMD;
      end
      ST_CMD: begin
        if (bus.rx_dv) begin
          addr_nxt = rx_addr;
          if (!addr_ok(rx_addr, NUM_REGS)) begin
            set_err_addr = 1'b1;
            tx_byte_nxt  = ERR_BYTE;
            tx_dv_nxt    = 1'b1;
            state_nxt    = ST_DROP;
          end else if (bus.rx_byte[CMD_RW_BIT]) begin
            state_nxt = ST_WDATA;
          end else begin
            reg_re_nxt   = 1'b1;
            reg_addr_nxt = rx_addr;
            state_nxt    = ST_RD_REQ;
          end
        end
      end
      ST_WDATA: begin
        if (bus.rx_dv) begin
          reg_we_nxt    = 1'b1;
          reg_addr_nxt  = addr;
          reg_wdata_nxt = bus.rx_byte;
          addr_nxt      = addr_inc(addr, NUM_REGS);
        end
      end
      // reg_re is already high during RD_REQ; the fetched data is taken in RD_LOAD.
      ST_RD_REQ: begin
        if (bus.rx_dv) set_err_ovr = 1'b1;
        state_nxt = ST_RD_LOAD;
      end
      ST_RD_LOAD: begin
        if (bus.rx_dv) set_err_ovr = 1'b1;
        tx_byte_nxt = bus.reg_rdata;
        tx_dv_nxt   = 1'b1;
        state_nxt   = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (bus.rx_dv) begin
          addr_nxt     = addr_inc(addr, NUM_REGS);
          reg_re_nxt   = 1'b1;
          reg_addr_nxt = addr_inc(addr, NUM_REGS);
          state_nxt    = ST_RD_REQ;
        end
      end
      ST_DROP: begin
        state_nxt = ST_DROP;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // A byte landing with the CS release still commits its write, but starts no new read.
    if (cs_end) begin
      state_nxt  = ST_IDLE;
      reg_re_nxt = 1'b0;
      tx_dv_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      addr           <= '0;
      bus.tx_byte    <= '0;
      bus.tx_dv      <= 1'b0;
      bus.reg_addr   <= '0;
      bus.reg_wdata  <= '0;
      bus.reg_we     <= 1'b0;
      bus.reg_re     <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.err_addr   <= 1'b0;
      bus.err_ovr    <= 1'b0;
    end else begin
      state          <= state_nxt;
      addr           <= addr_nxt;
      bus.tx_byte    <= tx_byte_nxt;
      bus.tx_dv      <= tx_dv_nxt;
      bus.reg_addr   <= reg_addr_nxt;
      bus.reg_wdata  <= reg_wdata_nxt;
      bus.reg_we     <= reg_we_nxt;
      bus.reg_re     <= reg_re_nxt;
      bus.frame_done <= cs_end;
      bus.err_addr   <= set_err_addr | (bus.err_addr & ~bus.err_clr);
      bus.err_ovr    <= set_err_ovr  | (bus.err_ovr  & ~bus.err_clr);
    end
  end

endmodule
